multicycle_ctrl_fsm: RTL and testbench

Parametrised control state machine for the multicycle RV32I datapath. It is the sequential successor to the single-cycle main decoder. It sequences every instruction through fetch, decode, execute, memory and writeback states, and handshakes with a variable-latency memory. It resolves all six branch conditions (including correct unsigned compares) and traps on bus timeout and, optionally, on illegal opcodes.

---
 rtl/multicycle_ctrl_fsm.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle RV32I control FSM with memory handshake and traps
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback states. A wait counter bounds every memory handshake; on expiry
// the FSM traps with cause 10. Build macro CTRL_ILLEGAL_TRAP_EN makes an
// unrecognised opcode trap with cause 01; without it such an opcode is a NOP.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   op, funct3, funct7b5            instruction fields (op stable after FETCH)
//   Zero, ALUR31, ALUCarry          flags of rs1-rs2 (ALUCarry=1: no borrow)
//   mem_ready                       memory completes current access
//   trap_ack                        handler accepts pending trap
//   mem_req, MemWrite, AdrSrc       memory request, write strobe, address select
//   IRWrite, PCWrite, RegWrite      datapath write enables
//   ResultSrc, ALUSrcA, ALUSrcB     datapath selects
//   ALUOp, ImmSrc                   ALU decode class, immediate format
//   trap, trap_cause                trap pending and its cause
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       ALUR31,
  input  logic       ALUCarry,
  input  logic       mem_ready,
  input  logic       trap_ack,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             timeout;
  logic             taken;
  logic             mem_state;

  // funct7b5 only matters to the ALU decoder downstream.
  logic unused_funct7b5;
  assign unused_funct7b5 = funct7b5;

  // Limit reached with no completion; mem_ready on the same cycle wins.
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = ALUR31;
      3'b101:  taken = ~ALUR31;
      3'b110:  taken = ~ALUCarry;
      3'b111:  taken = ALUCarry;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 3'b000;
    trap      = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
            cause_d = 2'b01;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_STORE) begin
          ImmSrc  = 3'b001;
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        // Shift-immediates carry a zero-extended shamt instead of a signed imm.
        ImmSrc  = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b101 : 3'b000;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        ImmSrc  = 3'b010;
        PCWrite = taken;
        state_d = S_FETCH;
      end
      S_JAL, S_JALR: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ImmSrc    = (state_q == S_JAL) ? 3'b011 : 3'b000;
        PCWrite   = 1'b1;
        RegWrite  = 1'b1;
        ResultSrc = 2'b10;
        state_d   = S_FETCH;
      end
      S_UPPER: begin
        ImmSrc    = 3'b100;
        RegWrite  = 1'b1;
        ResultSrc = 2'b11;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
        if (trap_ack) begin
          state_d = S_FETCH;
          cause_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every entry to a memory state and counts stalled cycles.
  always_comb begin
    cnt_d = '0;
    if (mem_state && state_d == state_q) cnt_d = cnt_q + 1'b1;
  end

  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, ALUR31, ALUCarry, mem_ready, trap_ack;
  logic       mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, trap_cause;
  logic [2:0] ImmSrc;
  logic [15:0] outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .ALUR31(ALUR31), .ALUCarry(ALUCarry), .mem_ready(mem_ready),
    .trap_ack(trap_ack), .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .trap(trap), .trap_cause(trap_cause)
  );

  assign outs = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
                 ResultSrc, ALUOp, ImmSrc, trap, trap_cause};

  function automatic logic [15:0] ex(input int mr, input int mw, input int irw,
                                     input int pcw, input int rw, input int adr,
                                     input int rs, input int aop, input int imm,
                                     input int tr, input int tc);
    return {mr[0], mw[0], irw[0], pcw[0], rw[0], adr[0],
            rs[1:0], aop[1:0], imm[2:0], tr[0], tc[1:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check the current cycle at the falling edge, then move one cycle on.
  task automatic cyc(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] e_fetch, e_wait;

  initial begin
    e_fetch = ex(1,0,1,1,0,0, 0,0,0, 0,0);
    e_wait  = ex(1,0,0,0,0,0, 0,0,0, 0,0);
    rst_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
    Zero = 1'b0; ALUR31 = 1'b0; ALUCarry = 1'b0; mem_ready = 1'b0; trap_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", outs, 16'h0);
    rst_n = 1'b1;
    cyc("idle_after_rst", 16'h0);

    // addi x1,x0,5
    op = 7'b0010011; funct3 = 3'b000; mem_ready = 1'b1;
    cyc("addi_fetch", e_fetch);
    cyc("addi_decode", 16'h0);
    cyc("addi_exec", ex(0,0,0,0,0,0, 0,2,0, 0,0));
    cyc("addi_wb", ex(0,0,0,0,1,0, 0,0,0, 0,0));

    // srli uses the zero-extended shift immediate
    funct3 = 3'b101;
    cyc("srli_fetch", e_fetch);
    cyc("srli_decode", 16'h0);
    cyc("srli_exec", ex(0,0,0,0,0,0, 0,2,5, 0,0));
    cyc("srli_wb", ex(0,0,0,0,1,0, 0,0,0, 0,0));

    // lw with three wait cycles in MEMRD
    op = 7'b0000011; funct3 = 3'b010;
    cyc("lw_fetch", e_fetch);
    cyc("lw_decode", 16'h0);
    cyc("lw_memadr", 16'h0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", ex(1,0,0,0,0,1, 0,0,0, 0,0));
    mem_ready = 1'b1;
    cyc("lw_rd_done", ex(1,0,0,0,0,1, 0,0,0, 0,0));
    cyc("lw_wb", ex(0,0,0,0,1,0, 1,0,0, 0,0));

    // sw zero-wait
    op = 7'b0100011;
    cyc("sw_fetch", e_fetch);
    cyc("sw_decode", 16'h0);
    cyc("sw_memadr", ex(0,0,0,0,0,0, 0,0,1, 0,0));
    cyc("sw_memwr", ex(1,1,0,0,0,1, 0,0,0, 0,0));

    // branches: bltu 0xFFFFFFFF vs 1 gives no borrow, so ALUCarry=1
    op = 7'b1100011; ALUCarry = 1'b1; Zero = 1'b0; ALUR31 = 1'b0;
    funct3 = 3'b110;
    cyc("bltu_fetch", e_fetch);
    cyc("bltu_decode", 16'h0);
    cyc("bltu_nottaken", ex(0,0,0,0,0,0, 0,1,2, 0,0));
    funct3 = 3'b111;
    cyc("bgeu_fetch", e_fetch);
    cyc("bgeu_decode", 16'h0);
    cyc("bgeu_taken", ex(0,0,0,1,0,0, 0,1,2, 0,0));
    funct3 = 3'b000; Zero = 1'b1;
    cyc("beq_fetch", e_fetch);
    cyc("beq_decode", 16'h0);
    cyc("beq_taken", ex(0,0,0,1,0,0, 0,1,2, 0,0));
    funct3 = 3'b100; ALUR31 = 1'b0;
    cyc("blt_fetch", e_fetch);
    cyc("blt_decode", 16'h0);
    cyc("blt_nottaken", ex(0,0,0,0,0,0, 0,1,2, 0,0));
    funct3 = 3'b010;
    cyc("br010_fetch", e_fetch);
    cyc("br010_decode", 16'h0);
    cyc("br010_never", ex(0,0,0,0,0,0, 0,1,2, 0,0));
    Zero = 1'b0; ALUCarry = 1'b0;

    // jal / jalr / lui, with a stray trap_ack that must be ignored
    trap_ack = 1'b1;
    op = 7'b1101111;
    cyc("jal_fetch", e_fetch);
    cyc("jal_decode", 16'h0);
    cyc("jal_exec", ex(0,0,0,1,1,0, 2,0,3, 0,0));
    op = 7'b1100111; funct3 = 3'b000;
    cyc("jalr_fetch", e_fetch);
    cyc("jalr_decode", 16'h0);
    cyc("jalr_exec", ex(0,0,0,1,1,0, 2,0,0, 0,0));
    op = 7'b0110111;
    cyc("lui_fetch", e_fetch);
    cyc("lui_decode", 16'h0);
    cyc("lui_exec", ex(0,0,0,0,1,0, 3,0,4, 0,0));
    trap_ack = 1'b0;

    // illegal opcode
    op = 7'b1111111;
    cyc("ill_fetch", e_fetch);
    cyc("ill_decode", 16'h0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    cyc("ill_trap", ex(0,0,0,0,0,0, 0,0,0, 1,1));
    trap_ack = 1'b1;
    cyc("ill_trap_ack", ex(0,0,0,0,0,0, 0,0,0, 1,1));
    trap_ack = 1'b0;
`endif

    // fetch timeout: 4 stalled cycles, then the limit cycle traps
    op = 7'b0010011; funct3 = 3'b000; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("to_wait", e_wait);
    cyc("to_limit", e_wait);
    cyc("to_trap", ex(0,0,0,0,0,0, 0,0,0, 1,2));
    trap_ack = 1'b1;
    cyc("to_trap_ack", ex(0,0,0,0,0,0, 0,0,0, 1,2));
    trap_ack = 1'b0;

    // mem_ready arriving exactly at the limit completes normally
    for (int i = 0; i < 4; i++) cyc("win_wait", e_wait);
    mem_ready = 1'b1;
    cyc("win_fetch", e_fetch);
    cyc("win_decode", 16'h0);
    cyc("win_exec", ex(0,0,0,0,0,0, 0,2,0, 0,0));
    cyc("win_wb", ex(0,0,0,0,1,0, 0,0,0, 0,0));

    // reset asserted in the middle of a store wait
    op = 7'b0100011;
    cyc("rsw_fetch", e_fetch);
    cyc("rsw_decode", 16'h0);
    cyc("rsw_memadr", ex(0,0,0,0,0,0, 0,0,1, 0,0));
    mem_ready = 1'b0;
    cyc("rsw_wait", ex(1,1,0,0,0,1, 0,0,0, 0,0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", outs, 16'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_hold", outs, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rst_mid_idle", 16'h0);
    cyc("rst_mid_fetch", e_fetch);
    cyc("rst_mid_decode", 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
